// File: rtl/irq_controller.sv
// irq_controller: latches synchronised source edges as pending, masks and prioritises them into one acked CPU interrupt
module irq_controller #(
  parameter int NSRC = 4,
  parameter int VW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src,
  input  logic            bus_sel,
  input  logic            bus_we,
  input  logic [1:0]      bus_addr,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  output logic            irq,
  output logic [VW-1:0]   irq_vec,
  input  logic            irq_ack
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state, state_nx;
  logic [NSRC-1:0] s1, s2, s3, pending, mask, act, rise, clr;
  logic [VW-1:0] grant, vec_nx;
  logic ack_clr, wr, rd, unused_ok;
  logic [31:0] rd_mux;
  assign rise = s2 & ~s3;
  assign act = pending & mask;
  assign wr = bus_sel & bus_we;
  assign rd = bus_sel & ~bus_we;
  assign irq = state == REQ;
  assign unused_ok = ^bus_wdata;
  // a rise in the same cycle as a clear re-sets the bit, so set wins
  assign clr = (ack_clr ? (NSRC'(1) << irq_vec) : '0) |
               ((wr && bus_addr == 2'd0) ? bus_wdata[NSRC-1:0] : '0);
  always_comb begin
    grant = '0;
    for (int i = NSRC - 1; i >= 0; i--) grant = act[i] ? VW'(i) : grant;
  end
  always_comb begin
    rd_mux = bus_addr == 2'd0 ? {{(32-NSRC){1'b0}}, pending} :
             bus_addr == 2'd1 ? {{(32-NSRC){1'b0}}, mask} :
             bus_addr == 2'd2 ? {irq, {(31-VW){1'b0}}, irq_vec} :
                                {{(32-NSRC){1'b0}}, s2};
  end
  always_comb begin
    state_nx = state;
    vec_nx = irq_vec;
    ack_clr = 1'b0;
    case (state)
      IDLE: begin
        state_nx = |act ? REQ : IDLE;
        vec_nx = |act ? grant : irq_vec;
      end
      REQ: begin
        ack_clr = irq_ack;
        state_nx = irq_ack ? HOLD : !act[irq_vec] ? IDLE : REQ;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      irq_vec <= '0;
    end else begin
      state <= state_nx;
      irq_vec <= vec_nx;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      pending <= '0;
      mask <= '0;
      bus_rdata <= '0;
    end else begin
      {s3, s2, s1} <= {s2, s1, src};
      pending <= (pending & ~clr) | rise;
      if (wr && bus_addr == 2'd1) mask <= bus_wdata[NSRC-1:0];
      if (rd) bus_rdata <= rd_mux;
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: scoreboard bench for irq_controller register port and request handshake
module tb_irq_controller;
  logic clk = 0, rst_n = 0, bus_sel = 0, bus_we = 0, irq_ack = 0, irq;
  logic [3:0] src = 0;
  logic [1:0] bus_addr = 0, irq_vec;
  logic [31:0] bus_wdata = 0, bus_rdata;
  logic [31:0] rd_q[$], vec_q[$];
  int n_vec = 0, n_err = 0, n;
  always #5 clk = ~clk;
  irq_controller #(.NSRC(4), .VW(2)) dut (
    .clk(clk), .rst_n(rst_n), .src(src), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .irq(irq), .irq_vec(irq_vec), .irq_ack(irq_ack)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_sel = 1; bus_we = 1; bus_addr = a; bus_wdata = d;
    step();
    bus_sel = 0; bus_we = 0;
  endtask
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] e);
    rd_q.push_back(e);
    bus_sel = 1; bus_we = 0; bus_addr = a;
    step();
    bus_sel = 0;
    chk(tag, bus_rdata, rd_q.pop_front());
  endtask
  task automatic wait_irq(input string tag, output int cnt);
    cnt = 0;
    while (!irq && cnt < 30) begin
      step();
      cnt++;
    end
    chk({tag, "_seen"}, irq, 1);
    chk({tag, "_vec"}, irq_vec, vec_q.pop_front());
  endtask
  task automatic ack(input string tag);
    irq_ack = 1;
    step();
    irq_ack = 0;
    chk(tag, irq, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    src = 4'hF;
    #23;
    chk("rst_irq", irq, 0);
    chk("rst_vec", irq_vec, 0);
    chk("rst_rdata", bus_rdata, 0);
    src = 0;
    step();
    rst_n = 1;
    repeat (3) step();
    rd("rst_pend", 0, 0);
    rd("rst_mask", 1, 0);
    rd("rst_stat", 2, 0);
    rd("rst_raw", 3, 0);
    wr(1, 32'h1);
    rd("t2_mask", 1, 32'h1);
    src = 4'h1; vec_q.push_back(0);
    wait_irq("t2", n);
    src = 0;
    chk("t2_lat", n, 4);
    rd("t2_stat", 2, 32'h8000_0000);
    ack("t2_ack");
    rd("t2_pend", 0, 0);
    repeat (3) step();
    chk("t2_idle", irq, 0);
    wr(1, 32'hFFFF_FFFF);
    rd("t3_mask", 1, 32'hF);
    src = 4'h6; vec_q.push_back(1); vec_q.push_back(2);
    wait_irq("t3a", n);
    chk("t3_lat", n, 4);
    rd("t3_raw", 3, 32'h6);
    src = 0;
    ack("t3a_ack");
    wait_irq("t3b", n);
    chk("t3_gap", n, 2);
    ack("t3b_ack");
    rd("t3_pend", 0, 0);
    src = 4'h1; vec_q.push_back(0);
    wait_irq("t4a", n);
    src = 0;
    repeat (3) step();
    src = 4'h1;
    step();
    step();
    irq_ack = 1;
    step();
    irq_ack = 0; src = 0;
    chk("t4_ack", irq, 0);
    rd("t4_pend", 0, 32'h1);
    vec_q.push_back(0);
    wait_irq("t4b", n);
    chk("t4_relat", n, 1);
    ack("t4b_ack");
    rd("t4_pend2", 0, 0);
    src = 4'h8; vec_q.push_back(3);
    wait_irq("t5", n);
    src = 0;
    rd("t5_stat", 2, 32'h8000_0003);
    wr(1, 0);
    chk("t5_req", irq, 1);
    step();
    chk("t5_wd", irq, 0);
    ack("t5_ign");
    rd("t5_pend", 0, 32'h8);
    wr(1, 32'h8); vec_q.push_back(3);
    wait_irq("t5r", n);
    #2 rst_n = 0;
    #1;
    chk("t6_async", irq, 0);
    chk("t6_rdata", bus_rdata, 0);
    step();
    rst_n = 1;
    step();
    rd("t6_pend", 0, 0);
    rd("t6_mask", 1, 0);
    rd("t6_stat", 2, 0);
    rd("t6_raw", 3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
